// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// selectable standard or first-word-fall-through read, and sticky error flags.
module sync_fifo_prog #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_WIDTH = 4,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_LEVEL  = DEPTH - 2,
  parameter int unsigned AE_LEVEL  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rd_data_o,
  output logic                 rd_valid_o,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error,
  output logic                 rd_error,
  input  logic                 err_clr_i
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [CNT_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     rd_ptr;
  logic [PTR_WIDTH-1:0] wr_addr;
  logic [PTR_WIDTH-1:0] rd_addr;
  logic                 wr_accept;
  logic                 rd_accept;
  logic                 wr_ovf;
  logic                 rd_unf;

  assign wr_addr = wr_ptr[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr[PTR_WIDTH-1:0];

  // Status decoded purely from registered pointers; no input reaches these.
  assign full         = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) && (wr_addr == rd_addr);
  assign empty        = (wr_ptr == rd_ptr);
  assign count_o      = wr_ptr - rd_ptr;
  assign almost_full  = (count_o >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_o <= CNT_W'(AE_LEVEL));

  // Request qualification; rejected requests only feed the error flags.
  assign wr_accept = wr_en_i & ~full;
  assign rd_accept = rd_en_i & ~empty;
  assign wr_ovf    = wr_en_i & full;
  assign rd_unf    = rd_en_i & empty;

  // Pointer registers; the extra MSB is the wrap bit so full/empty are distinct.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + CNT_W'(1);
      if (rd_accept) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_accept) mem[wr_addr] <= wr_data_i;
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_error <= 1'b0;
      rd_error <= 1'b0;
    end else begin
      wr_error <= (err_clr_i ? 1'b0 : wr_error) | wr_ovf;
      rd_error <= (err_clr_i ? 1'b0 : rd_error) | rd_unf;
    end
  end

  if (FWFT == 0) begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // Registered read port: data lands one cycle after the accepting edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) rd_data_q <= mem[rd_addr];
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end else begin : g_fwft
    // Head word shown directly; gated to zero when empty so reset reads as 0.
    assign rd_data_o  = empty ? '0 : mem[rd_addr];
    assign rd_valid_o = ~empty;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: standard-read instance plus a FWFT instance.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, af, ae, wr_err, rd_err;
  logic [4:0] count;

  logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [7:0] f_wr_data = '0;
  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_wr_err, f_rd_err;
  logic [4:0] f_count;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  bit exp_wr_err = 1'b0;
  bit exp_rd_err = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .FWFT(0)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
    .count_o(count), .wr_error(wr_err), .rd_error(rd_err), .err_clr_i(err_clr)
  );

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .FWFT(1)) dut_f (
    .clk_i(clk), .rst_i(rst), .wr_en_i(f_wr_en), .wr_data_i(f_wr_data),
    .rd_en_i(f_rd_en), .rd_data_o(f_rd_data), .rd_valid_o(f_rd_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count_o(f_count), .wr_error(f_wr_err), .rd_error(f_rd_err), .err_clr_i(1'b0)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: every valid pulse pops the scoreboard and compares data.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_data: unexpected valid word 0x%0h at %0t", rd_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data != e) begin
          failures++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", rd_data, e, $time);
        end
      end
    end
  end

  // One clock of stimulus on the main instance; model predicts status after the edge.
  task automatic do_cycle(input bit we, input logic [7:0] wd, input bit re, input bit clr);
    int occ;
    occ = model.size();
    wr_en = we; wr_data = wd; rd_en = re; err_clr = clr;
    if (re && occ > 0) exp_q.push_back(model.pop_front());
    if (we && occ < 16) model.push_back(wd);
    exp_wr_err = (clr ? 1'b0 : exp_wr_err) | (we && occ == 16);
    exp_rd_err = (clr ? 1'b0 : exp_rd_err) | (re && occ == 0);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    chk("count", int'(count), model.size());
    chk("full", int'(full), int'(model.size() == 16));
    chk("empty", int'(empty), int'(model.size() == 0));
    chk("almost_full", int'(af), int'(model.size() >= 14));
    chk("almost_empty", int'(ae), int'(model.size() <= 2));
    chk("wr_error", int'(wr_err), int'(exp_wr_err));
    chk("rd_error", int'(rd_err), int'(exp_rd_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ae", int'(ae), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(af), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_errors", int'({wr_err, rd_err}), 0);
    chk("rst_f_valid", int'(f_rd_valid), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // FWFT: first write visible next cycle, pop empties, head advances
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    chk("fwft_data_a5", int'(f_rd_data), 8'hA5);
    chk("fwft_valid", int'(f_rd_valid), 1);
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    chk("fwft_empty", int'(f_empty), 1);
    chk("fwft_valid0", int'(f_rd_valid), 0);
    for (int i = 0; i < 2; i++) begin
      f_wr_en = 1'b1; f_wr_data = (i == 0) ? 8'h11 : 8'h22;
      @(posedge clk); #1;
    end
    f_wr_en = 1'b0;
    chk("fwft_head_11", int'(f_rd_data), 8'h11);
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    chk("fwft_head_22", int'(f_rd_data), 8'h22);
    chk("fwft_count1", int'(f_count), 1);

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      if (i == 12) chk("af_at_13", int'(af), 0);
      if (i == 13) chk("af_at_14", int'(af), 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count16", int'(count), 16);

    // Overflow, clear coinciding with overflow (set wins), then clean clear
    do_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_wr_error", int'(wr_err), 1);
    do_cycle(1'b1, 8'hEF, 1'b0, 1'b0);
    do_cycle(1'b1, 8'hF0, 1'b0, 1'b1);
    chk("clr_set_wins", int'(wr_err), 1);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_wr_error", int'(wr_err), 0);
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Underflow: 16 writes, 18 reads, exactly 16 valid pulses
    v0 = valid_cnt;
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(8'h40 + 3 * i), 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 16) begin
        chk("unf_rd_error", int'(rd_err), 1);
        chk("unf_no_valid", int'(rd_valid), 0);
      end
    end
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("valid_pulses", valid_cnt - v0, 16);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read+write at empty: write wins, read rejected, no bypass
    do_cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("sim_empty_rd_err", int'(rd_err), 1);
    chk("sim_empty_no_valid", int'(rd_valid), 0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) do_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    // Simultaneous at full: read accepted, write rejected
    do_cycle(1'b1, 8'h99, 1'b1, 1'b0);
    chk("sim_full_count15", int'(count), 15);
    chk("sim_full_wr_err", int'(wr_err), 1);
    for (int i = 0; i < 15; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Streaming at count 8 for 40 cycles across pointer wraps
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) do_cycle(1'b1, 8'(8'hC8 + i), 1'b1, 1'b0);
    chk("stream_count8", int'(count), 8);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-stream at count 5
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count5", int'(count), 5);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_ae", int'(ae), 1);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_af", int'(af), 0);
    chk("mid_rst_valid", int'(rd_valid), 0);
    chk("mid_rst_data", int'(rd_data), 0);
    model.delete();
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_data", int'(rd_data), 8'h5A);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; a power of two and at least 4.
- PTR_WIDTH, 4, log2(DEPTH).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full threshold; range 1..DEPTH.
- AE_LEVEL, 2, almost_empty threshold; range 0..DEPTH-1.

REQ-002 The block SHALL have these ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wr_en_i  in  1  write request.
- wr_data_i  in  WIDTH  write data.
- rd_en_i  in  1  read (pop) request.
- rd_data_o  out  WIDTH  read data.
- rd_valid_o  out  1  rd_data_o holds a valid popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count_o  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- wr_error  out  1  sticky overflow flag.
- rd_error  out  1  sticky underflow flag.
- err_clr_i  in  1  synchronous clear of wr_error and rd_error.

Function
REQ-003 Storage SHALL be DEPTH x WIDTH, addressed by PTR_WIDTH+1-bit write and read pointers whose MSB is the wrap bit.
REQ-004 A write SHALL be accepted iff wr_en_i=1 and full=0: wr_data_i is stored at wr_ptr and wr_ptr increments modulo 2*DEPTH.
REQ-005 A read SHALL be accepted iff rd_en_i=1 and empty=0: rd_ptr increments modulo 2*DEPTH.
REQ-006 full and empty SHALL be decoded from registered pointers only: equal low bits with differing MSB means full; equal pointers means empty.
REQ-007 count_o SHALL equal wr_ptr - rd_ptr, computed PTR_WIDTH+1 bits wide, with no combinational path from any input.
REQ-008 almost_full and almost_empty SHALL be decoded from count_o and SHALL be valid in the same cycle as count_o.
REQ-009 When a read and a write are both accepted in one cycle, count_o SHALL stay unchanged, and this SHALL be legal at any occupancy from 1 to DEPTH-1.
REQ-010 At full, simultaneous wr_en_i and rd_en_i SHALL accept the read, reject the write, and set wr_error.
REQ-011 At empty, simultaneous wr_en_i and rd_en_i SHALL accept the write, reject the read, and set rd_error; the written word is not bypassed to the output.
REQ-012 When FWFT=0:
- rd_data_o is registered and loads mem[rd_ptr] on the edge that accepts a read (latency 1).
- rd_valid_o is high for exactly the cycle following each accepted read.
- rd_data_o holds its last value otherwise.
REQ-013 When FWFT=1:
- rd_data_o shows mem[rd_ptr] combinationally and rd_valid_o = ~empty.
- An accepted read advances to the next word on the following cycle.
- The first write into an empty FIFO is visible on rd_data_o one cycle after the write edge.
REQ-014 wr_error SHALL set on any cycle with wr_en_i=1 and full=0 false, i.e. full=1, and rd_error SHALL set on any cycle with rd_en_i=1 and empty=1.
REQ-015 Both error flags SHALL hold until the first clock edge with err_clr_i=1.
REQ-016 If err_clr_i coincides with a new error condition, the flag SHALL remain set (set wins).
REQ-017 A rejected request SHALL change no pointer, count_o, or memory content.
REQ-018 Pointer wrap-around SHALL be seamless: continuous streaming across any number of wraps loses and duplicates no words.

Reset
REQ-019 While rst_i=1, asynchronously and independent of clk_i, the block SHALL force:
- wr_ptr=0, rd_ptr=0, count_o=0.
- empty=1, almost_empty=1, full=0, almost_full=0.
- rd_data_o=0, rd_valid_o=0.
- wr_error=0, rd_error=0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Reset asserted mid-transfer SHALL discard all stored data; the first accepted write after release SHALL be the first word read.

Verification
REQ-022 The bench SHALL cover these directed scenarios, each with defaults unless stated:
- Fill: 16 writes from empty -> full=1 and count_o=16; almost_full=1 from count_o=14; no wr_error.
- Overflow: 18 writes, then err_clr_i pulse -> wr_error=1 from the 17th request until the cycle after clear; count_o stays 16; data read back equals the first 16 words.
- Underflow: 16 writes then 18 reads -> rd_error=1 on the 17th read; rd_valid_o pulses exactly 16 times with words in write order.
- Simultaneous: count_o=8 with wr_en_i and rd_en_i high for 40 cycles -> count_o stays 8 and pointers wrap at least twice with in-order data.
- FWFT=1: write 0xA5 into empty -> next cycle rd_data_o=0xA5 and rd_valid_o=1; pop -> empty=1 and rd_valid_o=0.
- Reset mid-stream: rst_i asserted at count_o=5 -> flags return to reset values immediately; the next write/read returns the new word.
